// File: rtl/mux2to1_arbiter_pkg.sv
// Shared types for the mux2to1_arbiter slice.
//   state_t   : arbiter FSM state. The encodings IDLE=00, G0=01, G1=10 are fixed.
//   cnt_width : width of the tenure counter, $clog2(MAXHOLD) but never below 1 bit.
package mux2to1_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  function automatic int cnt_width(input int maxhold);
    return (maxhold > 1) ? $clog2(maxhold) : 1;
  endfunction

endpackage

// File: rtl/mux2to1_arbiter_if.sv
// Shared-channel bundle between two requesters and the arbiter.
//   REQ0/REQ1 : level requests, held while the channel is wanted
//   D0/D1     : requester data (W bits)
//   GNT0/GNT1 : registered grants, never both high
//   PS        : mux select, 1 = D1 drives Y
//   Y/VALID   : registered shared output, qualified by VALID
// The slave modport is the arbiter side; the master modport is the requester side.
interface mux2to1_arbiter_if #(
  parameter int W = 1
);
  logic         REQ0;
  logic         REQ1;
  logic [W-1:0] D0;
  logic [W-1:0] D1;
  logic         GNT0;
  logic         GNT1;
  logic         PS;
  logic [W-1:0] Y;
  logic         VALID;

  modport master (
    output REQ0, REQ1, D0, D1,
    input  GNT0, GNT1, PS, Y, VALID
  );

  modport slave (
    input  REQ0, REQ1, D0, D1,
    output GNT0, GNT1, PS, Y, VALID
  );
endinterface

// File: rtl/mux2to1_reg.sv
// W-bit registered 2:1 mux with enable and asynchronous clear.
//   CP    : clock, rising edge
//   nCR   : asynchronous active-low clear (q=0, valid=0)
//   en    : load q from the selected input this edge; valid follows en
//   sel   : 1 selects d1, 0 selects d0
//   d0/d1 : data inputs
//   q     : registered output, holds when en is low
//   valid : registered copy of en
module mux2to1_reg #(
  parameter int W = 1
) (
  input  logic         CP,
  input  logic         nCR,
  input  logic         en,
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] q,
  output logic         valid
);

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) q <= sel ? d1 : d0;
    end
  end

endmodule

// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter plus registered 2:1 data path sharing one W-bit channel.
//   CP      : clock, rising edge
//   nCR     : asynchronous active-low clear
//   bus     : mux2to1_arbiter_if.slave (REQ0/1, D0/1 in; GNT0/1, PS, Y, VALID out)
// Parameters:
//   W       : data width
//   MAXHOLD : max consecutive grant cycles while the other side waits (>= 1)
// Grants and PS decode directly from the state register. Y/VALID are loaded from
// the granted source on each edge, so they lag the grant by one cycle.
module mux2to1_arbiter
  import mux2to1_arbiter_pkg::*;
#(
  parameter int W       = 1,
  parameter int MAXHOLD = 4
) (
  input  logic               CP,
  input  logic               nCR,
  mux2to1_arbiter_if.slave   bus
);

  localparam int            CW       = cnt_width(MAXHOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXHOLD - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;      // side granted most recently; 1 lets requester 0 win the first tie
  logic          at_limit;  // current tenure has used its MAXHOLD cycles

  assign at_limit = (cnt == CNT_LAST);

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.REQ0 && (!bus.REQ1 || last)) begin
            state <= G0;
            cnt   <= '0;
            last  <= 1'b0;
          end else if (bus.REQ1) begin
            state <= G1;
            cnt   <= '0;
            last  <= 1'b1;
          end
        end
        // Hand over when the holder lets go or its tenure expires with the
        // other side waiting; an expired tenure with nobody waiting renews.
        G0: begin
          if (bus.REQ1 && (!bus.REQ0 || at_limit)) begin
            state <= G1;
            cnt   <= '0;
            last  <= 1'b1;
          end else if (!bus.REQ0) begin
            state <= IDLE;
          end else if (at_limit) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        G1: begin
          if (bus.REQ0 && (!bus.REQ1 || at_limit)) begin
            state <= G0;
            cnt   <= '0;
            last  <= 1'b0;
          end else if (!bus.REQ1) begin
            state <= IDLE;
          end else if (at_limit) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // NOTE: the unused encoding 2'b11 recovers to IDLE rather than locking up.
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.GNT0 = (state == G0);
  assign bus.GNT1 = (state == G1);
  assign bus.PS   = (state == G1);

  mux2to1_reg #(.W(W)) u_reg (
    .CP    (CP),
    .nCR   (nCR),
    .en    (state != IDLE),
    .sel   (state == G1),
    .d0    (bus.D0),
    .d1    (bus.D1),
    .q     (bus.Y),
    .valid (bus.VALID)
  );

endmodule
